// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM encoding and operand width for addsub_sequencer.
// No ports; imported by the sequencer top.
package addsub_pkg;

    localparam int OPW = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_CAPTURE = S_CAPTURE,
        ST_EXEC    = S_EXEC,
        ST_DONE    = S_DONE
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter, 1-cycle press pulse.
// Ports: i_clk, i_rst_n (async low), i_key_n (raw active-low), o_press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    // pulse only on the released -> pressed flip
                    r_press  <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: debounced step button drives one add/sub on the 4-bit datapath.
// Ports: MAX10_CLK1_50, RESET_N, SW, KEY_STEP_N, MODE_SUB, dp_* (to/from adder),
//        res_sum/res_cout/res_ovf/res_valid, busy.
// Optional: ADDSUB_SEQ_ACCUM_EN reuses the last result as x on a press in DONE.
module addsub_sequencer
    import addsub_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic           MAX10_CLK1_50,
    input  logic           RESET_N,
    input  logic [7:0]     SW,
    input  logic           KEY_STEP_N,
    input  logic           MODE_SUB,
    output logic [OPW-1:0] dp_x,
    output logic [OPW-1:0] dp_y,
    output logic           dp_cin,
    input  logic [OPW-1:0] dp_sum,
    input  logic           dp_cout,
    input  logic           dp_ovf,
    output logic [OPW-1:0] res_sum,
    output logic           res_cout,
    output logic           res_ovf,
    output logic           res_valid,
    output logic           busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t         r_state;
    state_t         w_next;
    logic           w_press;
    logic [OPW-1:0] w_x_src;
    logic [3:0]     r_settle;
    logic [OPW-1:0] r_dp_x;
    logic [OPW-1:0] r_dp_y;
    logic           r_dp_cin;
    logic [OPW-1:0] r_res_sum;
    logic           r_res_cout;
    logic           r_res_ovf;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .i_clk  (MAX10_CLK1_50),
        .i_rst_n(RESET_N),
        .i_key_n(KEY_STEP_N),
        .o_press(w_press)
    );

`ifdef ADDSUB_SEQ_ACCUM_EN
    logic r_acc;

    // remembers whether the pending CAPTURE was launched from DONE
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc <= 1'b0;
        end else if (w_press && r_state == ST_IDLE) begin
            r_acc <= 1'b0;
        end else if (w_press && r_state == ST_DONE) begin
            r_acc <= 1'b1;
        end
    end

    assign w_x_src = r_acc ? r_res_sum : SW[7:4];
`else
    assign w_x_src = SW[7:4];
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_press) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_EXEC;
            ST_EXEC:    if (r_settle == SETTLE_LAST) w_next = ST_DONE;
            ST_DONE:    if (w_press) w_next = ST_CAPTURE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // dp_* registers double as the latched operands; they only change on capture
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_settle   <= '0;
            r_dp_x     <= '0;
            r_dp_y     <= '0;
            r_dp_cin   <= 1'b0;
            r_res_sum  <= '0;
            r_res_cout <= 1'b0;
            r_res_ovf  <= 1'b0;
        end else begin
            if (r_state == ST_CAPTURE) begin
                r_dp_x   <= w_x_src;
                r_dp_y   <= MODE_SUB ? ~SW[3:0] : SW[3:0];
                r_dp_cin <= MODE_SUB;
                r_settle <= '0;
            end
            if (r_state == ST_EXEC) begin
                r_settle <= r_settle + 1'b1;
                if (r_settle == SETTLE_LAST) begin
                    r_res_sum  <= dp_sum;
                    r_res_cout <= dp_cout;
                    r_res_ovf  <= dp_ovf;
                end
            end
        end
    end

    assign dp_x      = r_dp_x;
    assign dp_y      = r_dp_y;
    assign dp_cin    = r_dp_cin;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_ovf   = r_res_ovf;
    assign res_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_CAPTURE) || (r_state == ST_EXEC);

endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: directed vectors, scoreboard queue, decoupled monitor.
// Includes a behavioural 4-bit add/sub datapath driving dp_sum/cout/ovf.
module tb_addsub_sequencer;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] SW = 8'h00;
    logic       KEY_STEP_N = 1'b1;
    logic       MODE_SUB = 1'b0;
    logic [3:0] dp_x, dp_y, dp_sum, res_sum;
    logic       dp_cin, dp_cout, dp_ovf;
    logic       res_cout, res_ovf, res_valid, busy;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_res = 0;
    int   n_push = 0;

    always #5 clk = ~clk;

    addsub_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (4)
    ) dut (
        .MAX10_CLK1_50(clk),
        .RESET_N      (RESET_N),
        .SW           (SW),
        .KEY_STEP_N   (KEY_STEP_N),
        .MODE_SUB     (MODE_SUB),
        .dp_x         (dp_x),
        .dp_y         (dp_y),
        .dp_cin       (dp_cin),
        .dp_sum       (dp_sum),
        .dp_cout      (dp_cout),
        .dp_ovf       (dp_ovf),
        .res_sum      (res_sum),
        .res_cout     (res_cout),
        .res_ovf      (res_ovf),
        .res_valid    (res_valid),
        .busy         (busy)
    );

    always_comb begin
        {dp_cout, dp_sum} = {1'b0, dp_x} + {1'b0, dp_y} + {4'b0, dp_cin};
        dp_ovf = (dp_x[3] == dp_y[3]) && (dp_sum[3] != dp_x[3]);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: pop on each rising res_valid, time each busy run
    initial begin
        int   busy_run;
        logic prev_v;
        exp_t e;
        busy_run = 0;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!RESET_N) begin
                busy_run = 0;
                prev_v = 1'b0;
            end else begin
                if (busy) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    check("busy_len", busy_run, 5);
                    busy_run = 0;
                end
                if (res_valid && !prev_v) begin
                    n_res++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: sum %0d with empty queue", res_sum);
                    end else begin
                        e = sb.pop_front();
                        check("dp_x", dp_x, e.x);
                        check("dp_y", dp_y, e.y);
                        check("dp_cin", dp_cin, e.cin);
                        check("res_sum", res_sum, e.sum);
                        check("res_cout", res_cout, e.cout);
                        check("res_ovf", res_ovf, e.ovf);
                    end
                end
                prev_v = res_valid;
            end
        end
    end

    // waits for a new result; flips SW after capture, optionally injects a press in EXEC
    task automatic wait_result(input logic [7:0] sw, input logic md,
                               input int lat, input bit inject);
        int  k;
        int  nb;
        bit  done;
        k = 0;
        nb = 0;
        done = 0;
        while (!done && k < 60) begin
            @(posedge clk);
            k++;
            #1;
            if (busy) begin
                nb++;
                if (nb == 2) begin
                    SW = ~sw;
                    MODE_SUB = ~md;
                end
                if (inject && nb == 3) begin
                    force dut.w_press = 1'b1;
                    @(posedge clk);
                    k++;
                    #1;
                    release dut.w_press;
                    nb++;
                end
            end
            if (res_valid && nb > 0) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no result after %0d cycles", k);
        end else if (lat > 0) begin
            check("latency", k, lat);
        end
    endtask

    task automatic do_op(input logic [7:0] sw, input logic md,
                         input exp_t e, input int lat, input bit inject);
        @(negedge clk);
        SW = sw;
        MODE_SUB = md;
        sb.push_back(e);
        n_push++;
        KEY_STEP_N = 1'b0;
        wait_result(sw, md, lat, inject);
        @(negedge clk);
        KEY_STEP_N = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        KEY_STEP_N = 1'b1;
        RESET_N = 1'b0;
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pre_op();
`ifdef ADDSUB_SEQ_ACCUM_EN
        do_reset();
`endif
    endtask

    initial begin
        // reset state
        #1;
        check("rst_dp_x", dp_x, 0);
        check("rst_dp_y", dp_y, 0);
        check("rst_dp_cin", dp_cin, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_cout", res_cout, 0);
        check("rst_res_ovf", res_ovf, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        RESET_N = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", res_valid, 0);

        // directed add/sub vectors
        do_op(8'h35, 1'b0, '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1}, 12, 0);
        pre_op();
        do_op(8'h23, 1'b1, '{4'h2, 4'hC, 1'b1, 4'hF, 1'b0, 1'b0}, 12, 0);
        pre_op();
        do_op(8'h7F, 1'b0, '{4'h7, 4'hF, 1'b0, 4'h6, 1'b1, 1'b0}, 12, 0);
        pre_op();
        do_op(8'h53, 1'b1, '{4'h5, 4'hC, 1'b1, 4'h2, 1'b1, 1'b0}, 12, 0);
        pre_op();
        do_op(8'h81, 1'b1, '{4'h8, 4'hE, 1'b1, 4'h7, 1'b1, 1'b1}, 12, 0);

        // bouncing press then bouncing release: one operation only
        pre_op();
        @(negedge clk);
        SW = 8'h11;
        MODE_SUB = 1'b0;
        sb.push_back('{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0});
        n_push++;
        for (int i = 0; i < 5; i++) begin
            KEY_STEP_N = i[0];
            repeat (2) @(negedge clk);
        end
        KEY_STEP_N = 1'b0;
        wait_result(8'h11, 1'b0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            KEY_STEP_N = ~i[0];
            repeat (2) @(negedge clk);
        end
        KEY_STEP_N = 1'b1;
        repeat (30) @(negedge clk);
        check("bounce_results", n_res, n_push);
        check("bounce_valid", res_valid, 1);

        // extra press during EXEC is dropped
        pre_op();
        do_op(8'h44, 1'b0, '{4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1}, 12, 1);
        repeat (20) @(negedge clk);
        check("exec_press_results", n_res, n_push);

        // reset mid-EXEC
        @(negedge clk);
        SW = 8'h66;
        MODE_SUB = 1'b0;
        KEY_STEP_N = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_abort_busy", busy, 1);
        KEY_STEP_N = 1'b1;
        RESET_N = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_dp_x", dp_x, 0);
        check("abort_dp_y", dp_y, 0);
        check("abort_res_sum", res_sum, 0);
        @(posedge clk);
        #1;
        RESET_N = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_valid", res_valid, 0);

        do_op(8'hA5, 1'b1, '{4'hA, 4'hA, 1'b1, 4'h5, 1'b1, 1'b1}, 12, 0);

`ifdef ADDSUB_SEQ_ACCUM_EN
        do_reset();
        do_op(8'h27, 1'b0, '{4'h2, 4'h7, 1'b0, 4'h9, 1'b0, 1'b1}, 12, 0);
        do_op(8'hF7, 1'b0, '{4'h9, 4'h7, 1'b0, 4'h0, 1'b1, 1'b0}, 12, 0);
        do_op(8'hF7, 1'b0, '{4'h0, 4'h7, 1'b0, 4'h7, 1'b0, 1'b0}, 12, 0);
`endif

        repeat (10) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("n_results", n_res, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
- Clocked controller that sequences the 4-bit ripple add/subtract datapath (x, y, carry-in in; sum, carry-out, overflow out) from board inputs.
- Debounces the step button, captures operands from SW, drives the datapath with add/subtract encoding, waits a settle window, then registers the result and flags for the seven-segment display stage.
- Sits between the board I/O (SW, KEY) and the existing adder/display blocks, inside the lab top level.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles KEY_STEP_N must be stable low/high before a press/release is accepted (10 ms at 50 MHz).
- SETTLE_CYCLES, 4, cycles operands are held on the datapath before the result is sampled (1..15).

Ports:
- MAX10_CLK1_50  input  1  system clock, 50 MHz, all state on rising edge.
- RESET_N  input  1  asynchronous active-low reset (top level ties to KEY[1]).
- SW  input  8  operands: SW[7:4] = x, SW[3:0] = y.
- KEY_STEP_N  input  1  raw active-low step button (KEY[0]), asynchronous to clock.
- MODE_SUB  input  1  sampled at capture: 0 = x+y, 1 = x-y.
- dp_x  output  4  datapath operand x.
- dp_y  output  4  datapath operand y, already inverted when subtracting.
- dp_cin  output  1  datapath carry-in (1 when subtracting).
- dp_sum  input  4  datapath sum.
- dp_cout  input  1  datapath carry-out.
- dp_ovf  input  1  datapath signed overflow.
- res_sum  output  4  registered result.
- res_cout  output  1  registered carry-out.
- res_ovf  output  1  registered overflow.
- res_valid  output  1  high while res_* holds a completed result.
- busy  output  1  high in CAPTURE/EXEC.

Behaviour:
- Reset, asynchronous while RESET_N = 0:
  - All outputs 0, FSM = IDLE, synchronizer flops = 1 (released).
  - Debounce counter = 0, stable button state = released.
- Button input path:
  - KEY_STEP_N passes through a 2-flop synchronizer.
  - The debounce counter counts while the synced value differs from the stable state and resets to 0 on any match.
  - The stable state flips when the counter reaches DEBOUNCE_CYCLES-1.
  - A press pulse (1 cycle) is generated on the stable high→low transition only. Release generates no pulse.
- FSM states IDLE, CAPTURE, EXEC, DONE:
  - IDLE: waits for press → CAPTURE.
  - CAPTURE (1 cycle): latch x_r = SW[7:4], y_r = SW[3:0], sub_r = MODE_SUB; clear res_valid; busy = 1 → EXEC.
  - EXEC: dp_x = x_r, dp_y = sub_r ? ~y_r : y_r, dp_cin = sub_r. The settle counter starts at 0 and increments each cycle. When it reaches SETTLE_CYCLES-1, register res_sum/res_cout/res_ovf from the dp_* inputs at that edge → DONE. busy = 1 throughout.
  - DONE: res_valid = 1, busy = 0. A press → CAPTURE (new operation). Otherwise stays.
- dp_* outputs are registered and held constant outside EXEC (last values kept). They are 0 after reset.
- A press during CAPTURE/EXEC is ignored (dropped, not queued).
- SW/MODE_SUB changes after CAPTURE do not affect the running operation.
- Latency, press pulse to res_valid: 1 (CAPTURE) + SETTLE_CYCLES (EXEC) + 1 cycles. Default = 6.
- Reset mid-EXEC aborts immediately. No partial result is retained.
- Subtraction semantics: res_cout = 1 means no borrow. res_ovf follows two's-complement rules from dp_ovf.

Optional Feature:
- Macro ADDSUB_SEQ_ACCUM_EN.
- Defined: add ACCUMULATE mode. On a press in DONE, x_r is loaded from res_sum instead of SW[7:4]; y and MODE_SUB are still sampled from SW. Results wrap modulo 16, and res_ovf is recomputed each step (not sticky). A press in IDLE still loads x from SW.
- Undefined: x is always SW[7:4]; no extra logic.

Decomposition:
- Shared package addsub_pkg:
  - state encoding localparams S_IDLE=2'd0, S_CAPTURE=2'd1, S_EXEC=2'd2, S_DONE=2'd3.
  - operand width constant OPW=4.
- One natural sub-module: key_debounce (synchronizer + debounce counter + press-pulse output, DEBOUNCE_CYCLES parameter). It is reusable for other KEY inputs.

Test Plan:
- Reset then idle, with DEBOUNCE_CYCLES=4 and SETTLE_CYCLES=4 in the bench: all outputs 0, FSM IDLE, no press with KEY_STEP_N held high.
- SW=8'h35, MODE_SUB=0, one clean press → dp_x=3, dp_y=5, dp_cin=0; 6 cycles after the pulse, res_sum=8, res_cout=0, res_ovf=1, res_valid=1.
- SW=8'h23, MODE_SUB=1 → dp_y=4'hC, dp_cin=1; res_sum=F, res_cout=0, res_ovf=0.
- Bouncing press (toggles every 2 cycles for 10 cycles, then stable low) → exactly one CAPTURE; release bounce → no second operation.
- Second press asserted during EXEC → ignored; busy stays high for the original 5 cycles; one result only.
- RESET_N low for 1 cycle mid-EXEC → outputs 0 asynchronously, FSM IDLE. With ADDSUB_SEQ_ACCUM_EN, three presses with SW[3:0]=7, add → res_sum sequence 7+x0, then +7, then +7 mod 16.
